// File: rtl/onchip_ram_pkg.sv
// rtl/onchip_ram_pkg.sv - shared types, constants and helpers for the on-chip RAM slave
package onchip_ram_pkg;

  // Controller state: FILL clears the array after reset, READY serves the bus.
  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } ram_state_t;

  // Supported read pipeline depths.
  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  // Number of byte lanes in one data word.
  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// rtl/onchip_ram_core.sv - single-port byte-enabled synchronous-read array
module onchip_ram_core
  import onchip_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic                re,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int BE_W = bytes_per_word(DATA_W);

  // No reset on the storage or its output register so the array maps onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes and a registered read; the read register only moves on a
  // launched read so it keeps the last returned word otherwise.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[b]) begin
            mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end
      if (re) begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/onchip_ram_avl.sv
// rtl/onchip_ram_avl.sv - parametrised on-chip RAM Avalon-MM slave with pipelined reads and zero-fill
module onchip_ram_avl
  import onchip_ram_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int READ_LATENCY = 2,
  parameter int ZERO_FILL    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  input  logic                reset_req,
  output logic                waitrequest,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                init_done
);

  // Parameter sanity, caught at elaboration.
  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 128 || DEPTH < 2 ||
      READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_params
    $error("onchip_ram_avl: illegal DATA_W, DEPTH or READ_LATENCY");
  end

  // Fill counter and range check are one bit wider than the address so DEPTH
  // and DEPTH-1 are represented exactly, whatever DEPTH is.
  localparam logic [ADDR_W:0] FILL_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W+1)'(DEPTH);

  logic              en;
  ram_state_t        state_q, state_d;
  logic [ADDR_W:0]   fill_cnt_q, fill_cnt_d;
  logic              accept;
  logic              in_range;
  logic              launch;

  logic              core_we;
  logic              core_re;
  logic [DATA_W/8-1:0] core_be;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;

  logic              s1_valid;
  logic              s1_rng;
  logic [DATA_W-1:0] s1_data;
  logic              valid_last;

  assign en          = clken & ~reset_req;
  assign waitrequest = (state_q == FILL) | ~en;
  assign accept      = chipselect & ~waitrequest;
  assign in_range    = {1'b0, address} < DEPTH_X;
  assign launch      = accept & read & ~write;
  assign init_done   = (state_q == READY);

  // State register and fill counter; everything freezes while en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= (ZERO_FILL != 0) ? FILL : READY;
      fill_cnt_q <= '0;
    end else if (en) begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // Next state: walk the fill counter across the array, then serve the bus forever.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    if (state_q == FILL) begin
      if (fill_cnt_q == FILL_LAST) begin
        state_d = READY;
      end else begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
    end
  end

  // Array port mux: zero-fill writes during FILL, bus accesses in READY.
  // Out-of-range accesses never write, and read a harmless in-range word that
  // is masked to zero at the pipeline output.
  always_comb begin
    core_we    = 1'b0;
    core_re    = launch;
    core_be    = byteenable;
    core_addr  = in_range ? address : '0;
    core_wdata = writedata;
    if (state_q == FILL) begin
      core_we    = 1'b1;
      core_be    = '1;
      core_addr  = fill_cnt_q[ADDR_W-1:0];
      core_wdata = '0;
    end else begin
      core_we = accept & write & in_range;
    end
  end

  onchip_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .en    (en),
    .we    (core_we),
    .re    (core_re),
    .be    (core_be),
    .addr  (core_addr),
    .wdata (core_wdata),
    .rdata (core_rdata)
  );

  // Stage-1 valid rides alongside the array output; the range flag is kept
  // with the last launched read so the masked data holds between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_rng   <= 1'b0;
    end else if (en) begin
      s1_valid <= launch;
      if (launch) begin
        s1_rng <= in_range;
      end
    end
  end

  assign s1_data = s1_rng ? core_rdata : '0;

  if (READ_LATENCY == 2) begin : g_lat2
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;

    // Output register stage; data only loads when a valid word arrives.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else if (en) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign valid_last = s2_valid;
    assign readdata   = s2_data;
  end else begin : g_lat1
    assign valid_last = s1_valid;
    assign readdata   = s1_data;
  end

  // A held pipeline delivers its pulse on the first cycle en comes back.
  assign readdatavalid = valid_last & en;

endmodule

// File: tb/tb_onchip_ram_avl.sv
// tb/tb_onchip_ram_avl.sv - randomized scoreboard bench for onchip_ram_avl (LAT=2/DEPTH=16 and LAT=1/DEPTH=10)
module tb_onchip_ram_avl;

  logic        clk;
  logic        reset;
  logic [3:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        clken;
  logic        reset_req;

  logic        wr_a, rdv_a, init_a;
  logic [31:0] rdata_a;
  logic        wr_b, rdv_b, init_b;
  logic [31:0] rdata_b;

  onchip_ram_avl #(.DATA_W(32), .DEPTH(16), .READ_LATENCY(2), .ZERO_FILL(1)) dut_a (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .waitrequest(wr_a), .readdata(rdata_a),
    .readdatavalid(rdv_a), .init_done(init_a)
  );

  onchip_ram_avl #(.DATA_W(32), .DEPTH(10), .READ_LATENCY(1), .ZERO_FILL(1)) dut_b (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .waitrequest(wr_b), .readdata(rdata_b),
    .readdatavalid(rdv_b), .init_done(init_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a word array per DUT, remaining fill cycles, and a list
  // of outstanding reads, each needing LAT more enabled cycles to appear.
  typedef struct {
    int          id;
    int          cnt;
    logic [31:0] data;
  } pend_t;

  logic [31:0] mem_m [2][16];
  int          fill_left [2];
  logic [31:0] last_m [2];
  pend_t       pq [$];

  function automatic int dep(input int d);
    return (d == 0) ? 16 : 10;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic model_eval();
    logic        en_m;
    logic        o_wr, o_rdv, o_init;
    logic [31:0] o_rd;
    logic        exp_rdv;
    bit          any_left;
    string       dn;
    pend_t       nq [$];
    pend_t       e;
    en_m = clken & ~reset_req;
    for (int d = 0; d < 2; d++) begin
      dn     = (d == 0) ? "a" : "b";
      o_wr   = (d == 0) ? wr_a   : wr_b;
      o_rdv  = (d == 0) ? rdv_a  : rdv_b;
      o_init = (d == 0) ? init_a : init_b;
      o_rd   = (d == 0) ? rdata_a : rdata_b;
      if (reset) begin
        fill_left[d] = dep(d);
        last_m[d]    = '0;
        for (int k = 0; k < 16; k++) mem_m[d][k] = '0;
      end
      check({dn, ".waitrequest"}, 32'(o_wr), 32'((fill_left[d] > 0) || !en_m));
      check({dn, ".init_done"}, 32'(o_init), 32'(fill_left[d] == 0));
      exp_rdv  = 1'b0;
      any_left = 1'b0;
      nq.delete();
      foreach (pq[i]) begin
        e = pq[i];
        if (e.id != d) begin
          nq.push_back(e);
        end else if (!reset) begin
          if (en_m) e.cnt--;
          if (e.cnt == 0) begin
            exp_rdv   = 1'b1;
            last_m[d] = e.data;
          end else begin
            nq.push_back(e);
            any_left = 1'b1;
          end
        end
      end
      pq = nq;
      check({dn, ".readdatavalid"}, 32'(o_rdv), 32'(exp_rdv));
      if (exp_rdv || !any_left) check({dn, ".readdata"}, o_rd, last_m[d]);
      if (!reset && en_m) begin
        if (fill_left[d] > 0) begin
          fill_left[d]--;
        end else if (chipselect) begin
          if (write) begin
            if (int'(address) < dep(d)) begin
              for (int b = 0; b < 4; b++)
                if (byteenable[b]) mem_m[d][address][b*8 +: 8] = writedata[b*8 +: 8];
            end
          end else if (read) begin
            e.id   = d;
            e.cnt  = lat(d);
            e.data = (int'(address) < dep(d)) ? mem_m[d][address] : 32'h0;
            pq.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] dat, input logic [3:0] be);
    chipselect = 1'b1; read = 1'b0; write = 1'b1;
    address = a; writedata = dat; byteenable = be;
    step();
  endtask

  task automatic rd(input logic [3:0] a);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    step();
  endtask

  task automatic do_reset();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Count cycles until dut_a reports init_done, optionally pulsing reset_req.
  task automatic count_fill(input int pulse_start, input int pulse_len, output int n);
    n = 0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (init_a) break;
      reset_req = (pulse_len > 0) && (n >= pulse_start) && (n < pulse_start + pulse_len);
      n++;
      step();
    end
    reset_req = 1'b0;
  endtask

  int nfill;
  int op;

  initial begin
    reset = 1'b1; address = '0; byteenable = '0; chipselect = 1'b0;
    read = 1'b0; write = 1'b0; writedata = '0; clken = 1'b1; reset_req = 1'b0;
    for (int d = 0; d < 2; d++) begin
      fill_left[d] = dep(d);
      last_m[d] = '0;
    end
    step();
    step();
    reset = 1'b0;

    count_fill(0, 0, nfill);
    check("fill_len", 32'(nfill), 32'd16);
    idle(2);

    rd(4'd5);
    idle(3);
    wr(4'd3, 32'hDEADBEEF, 4'b1111);
    wr(4'd3, 32'h00AA0000, 4'b0100);
    rd(4'd3);
    idle(3);

    for (int i = 0; i < 4; i++) wr(4'(i), 32'h10 + 32'(i), 4'b1111);
    for (int i = 0; i < 4; i++) rd(4'(i));
    idle(3);

    rd(4'd1);
    clken = 1'b0; idle(3);
    clken = 1'b1; idle(3);
    rd(4'd2);
    idle(1);
    clken = 1'b0; idle(3);
    clken = 1'b1; idle(3);

    wr(4'd12, 32'h55, 4'b1111);
    rd(4'd12);
    idle(2);
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 4'd2;
    writedata = 32'hA5A5_0002; byteenable = 4'b1111;
    step();
    idle(3);
    rd(4'd2);
    idle(3);

    for (int i = 0; i < 1500; i++) begin
      op         = int'($urandom_range(0, 9));
      chipselect = ($urandom_range(0, 9) != 0);
      read       = (op <= 4) || (op == 9);
      write      = (op >= 5);
      address    = 4'($urandom_range(0, 15));
      byteenable = 4'($urandom);
      writedata  = $urandom;
      clken      = ($urandom_range(0, 9) != 0);
      reset_req  = ($urandom_range(0, 19) == 0);
      step();
    end
    clken = 1'b1; reset_req = 1'b0;
    idle(3);

    rd(4'd3);
    do_reset();
    count_fill(0, 0, nfill);
    check("fill_after_inflight_reset", 32'(nfill), 32'd16);

    do_reset();
    idle(7);
    reset = 1'b1;
    #2;
    step();
    reset = 1'b0;
    count_fill(0, 0, nfill);
    check("fill_restart", 32'(nfill), 32'd16);

    do_reset();
    count_fill(5, 4, nfill);
    check("fill_reset_req", 32'(nfill), 32'd20);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
